// File: rtl/fetch_seq_pkg.sv
// Shared types and constants for the instruction-fetch sequencer and decode hazard logic.
package fetch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_HOLD,
    ST_WAIT_RESOLVE
  } fetch_state_t;

  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam int PC_STEP = 4;

endpackage

// File: rtl/fetch_seq_if.sv
// Fetch-side bundle: imem request/ack, decode valid/ready, execute resolve and status.
interface fetch_seq_if #(
  parameter int XLEN = 32
) ();

  logic            fetch_en;
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_ack;
  logic [XLEN-1:0] imem_rdata;
  logic            inst_valid;
  logic            inst_ready;
  logic [XLEN-1:0] inst_out;
  logic [XLEN-1:0] inst_pc;
  logic [XLEN-1:0] inst_pc4;
  logic            resolve_valid;
  logic            resolve_taken;
  logic [XLEN-1:0] resolve_target;
  logic            misalign;
  logic [31:0]     bubble_cnt;

  modport master (
    input  fetch_en,
    output imem_req, imem_addr,
    input  imem_ack, imem_rdata,
    output inst_valid,
    input  inst_ready,
    output inst_out, inst_pc, inst_pc4,
    input  resolve_valid, resolve_taken, resolve_target,
    output misalign, bubble_cnt
  );

  modport slave (
    output fetch_en,
    input  imem_req, imem_addr,
    output imem_ack, imem_rdata,
    input  inst_valid,
    output inst_ready,
    input  inst_out, inst_pc, inst_pc4,
    output resolve_valid, resolve_taken, resolve_target,
    input  misalign, bubble_cnt
  );

endinterface

// File: rtl/fetch_seq_is_ctrl_xfer.sv
// Flags opcodes that redirect control flow (JAL, JALR, conditional branch).
module is_ctrl_xfer
  import fetch_pkg::*;
(
  input  logic [6:0] opcode,
  output logic       is_xfer
);

  assign is_xfer = (opcode == OP_JAL) || (opcode == OP_JALR) || (opcode == OP_BRANCH);

endmodule

// File: rtl/fetch_seq.sv
// Instruction-fetch sequencer: owns the PC, runs the imem handshake and stalls
// fetch behind every control transfer until execute resolves it.
//
// state           | meaning
// ST_IDLE         | parked, no request; leaves when fetch_en is high
// ST_FETCH        | imem_req high at pc, waiting for imem_ack
// ST_HOLD         | instruction presented to decode, waiting for inst_ready
// ST_WAIT_RESOLVE | control transfer issued, waiting for resolve_valid
module fetch_seq
  import fetch_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input logic         CLK,
  input logic         RESET,
  fetch_seq_if.master bus
);

  localparam logic [XLEN-1:0] STEP = XLEN'(PC_STEP);

  fetch_state_t    state_q;
  fetch_state_t    state_d;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] pc_d;
  logic [XLEN-1:0] inst_out_q;
  logic [XLEN-1:0] inst_pc_q;
  logic            misalign_q;
  logic            misalign_d;
  logic [31:0]     bubble_q;
  logic            capture;
  logic            hold_xfer;

  is_ctrl_xfer u_is_ctrl_xfer (
    .opcode  (inst_out_q[6:0]),
    .is_xfer (hold_xfer)
  );

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    capture    = 1'b0;
    misalign_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.fetch_en) state_d = ST_FETCH;
      end
      ST_FETCH: begin
        if (bus.imem_ack) begin
          capture = 1'b1;
          state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (bus.inst_ready) begin
          if (hold_xfer) begin
            state_d = ST_WAIT_RESOLVE;
          end else begin
            pc_d    = pc_q + STEP;
            state_d = bus.fetch_en ? ST_FETCH : ST_IDLE;
          end
        end
      end
      ST_WAIT_RESOLVE: begin
        if (bus.resolve_valid) begin
          // Target is forced word-aligned; the dropped low bits are reported once.
          if (bus.resolve_taken) begin
            pc_d       = {bus.resolve_target[XLEN-1:2], 2'b00};
            misalign_d = |bus.resolve_target[1:0];
          end else begin
            pc_d = pc_q + STEP;
          end
          state_d = bus.fetch_en ? ST_FETCH : ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      pc_q       <= RESET_PC;
      inst_out_q <= '0;
      inst_pc_q  <= '0;
      misalign_q <= 1'b0;
      bubble_q   <= '0;
    end else begin
      pc_q       <= pc_d;
      misalign_q <= misalign_d;
      if (capture) begin
        inst_out_q <= bus.imem_rdata;
        inst_pc_q  <= pc_q;
      end
      if ((state_q == ST_WAIT_RESOLVE) && (bubble_q != 32'hFFFF_FFFF)) begin
        bubble_q <= bubble_q + 32'd1;
      end
    end
  end

  assign bus.imem_req   = (state_q == ST_FETCH);
  assign bus.imem_addr  = pc_q;
  assign bus.inst_valid = (state_q == ST_HOLD);
  assign bus.inst_out   = inst_out_q;
  assign bus.inst_pc    = inst_pc_q;
  assign bus.inst_pc4   = inst_pc_q + STEP;
  assign bus.misalign   = misalign_q;
  assign bus.bubble_cnt = bubble_q;

endmodule

// File: tb/tb_fetch_seq.sv
// Bench for fetch_seq: directed scenarios plus a randomized run against a
// transaction-level PC/instruction model.
module tb_fetch_seq;

  logic CLK = 1'b0;
  logic RESET = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   cyc_n = 0;

  fetch_seq_if #(.XLEN(32)) b0 ();
  fetch_seq_if #(.XLEN(32)) b1 ();

  fetch_seq #(.XLEN(32), .RESET_PC(32'h0000_0000)) dut0 (.CLK(CLK), .RESET(RESET), .bus(b0));
  fetch_seq #(.XLEN(32), .RESET_PC(32'hFFFF_FFFC)) dut1 (.CLK(CLK), .RESET(RESET), .bus(b1));

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc_n <= cyc_n + 1;

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  localparam logic [31:0] W_ADDI = 32'h0010_0093;
  localparam logic [31:0] W_BEQ  = 32'h0020_8063;
  localparam logic [31:0] W_JALR = 32'h0000_80E7;
  localparam logic [31:0] W_JAL  = 32'h0040_006F;

  task automatic cyc();
    @(negedge CLK);
  endtask

  task automatic init_inputs(input logic fen);
    b0.fetch_en = fen; b0.imem_ack = 0; b0.imem_rdata = '0; b0.inst_ready = 0;
    b0.resolve_valid = 0; b0.resolve_taken = 0; b0.resolve_target = '0;
    b1.fetch_en = 0; b1.imem_ack = 0; b1.imem_rdata = '0; b1.inst_ready = 0;
    b1.resolve_valid = 0; b1.resolve_taken = 0; b1.resolve_target = '0;
  endtask

  task automatic do_reset(input logic fen);
    init_inputs(fen);
    RESET = 1;
    repeat (2) cyc();
    RESET = 0;
  endtask

  task automatic wait_req(output logic [31:0] addr, output int at);
    int n = 0;
    while (b0.imem_req !== 1'b1 && n < 40) begin cyc(); n++; end
    checks++;
    if (b0.imem_req !== 1'b1) begin
      errors++; $display("FAIL req_timeout imem_req=%b want 1", b0.imem_req);
    end
    addr = b0.imem_addr; at = cyc_n;
  endtask

  task automatic ack_with(input logic [31:0] word, input int delay);
    repeat (delay) cyc();
    b0.imem_ack = 1; b0.imem_rdata = word;
    cyc();
    b0.imem_ack = 0;
  endtask

  function automatic bit xfer_op(input logic [31:0] w);
    logic [6:0] op;
    op = w[6:0];
    return (op == 7'h6F) || (op == 7'h67) || (op == 7'h63);
  endfunction

  function automatic logic [31:0] gen_word();
    logic [6:0]  ops [6];
    logic [31:0] r;
    ops = '{7'h13, 7'h03, 7'h33, 7'h6F, 7'h67, 7'h63};
    r = $urandom;
    return {r[31:7], ops[$urandom_range(0, 5)]};
  endfunction

  task automatic test_reset();
    do_reset(1);
    init_inputs(1);
    RESET = 1;
    cyc(); cyc();
    RESET = 0;
    checks++; if (b0.imem_req !== 1'b0) begin errors++; $display("FAIL rst_req got %b want 0", b0.imem_req); end
    checks++; if (b0.inst_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b want 0", b0.inst_valid); end
    checks++; if (b0.inst_out !== 32'h0 || b0.inst_pc !== 32'h0) begin
      errors++; $display("FAIL rst_inst out=%h pc=%h want 0/0", b0.inst_out, b0.inst_pc); end
    checks++; if (b0.misalign !== 1'b0 || b0.bubble_cnt !== 32'h0) begin
      errors++; $display("FAIL rst_status mis=%b bub=%0d want 0/0", b0.misalign, b0.bubble_cnt); end
    checks++; if (b0.imem_addr !== 32'h0) begin errors++; $display("FAIL rst_pc got %h want 0", b0.imem_addr); end
    cyc();
    checks++; if (b0.imem_req !== 1'b1) begin errors++; $display("FAIL idle_exit got %b want 1", b0.imem_req); end
  endtask

  task automatic test_sequential(input int delay, input int period);
    logic [31:0] a;
    logic [31:0] w;
    int t, t_prev;
    do_reset(1);
    b0.inst_ready = 1;
    t_prev = 0;
    for (int i = 0; i < 4; i++) begin
      wait_req(a, t);
      checks++; if (a !== 32'(i * 4)) begin errors++; $display("FAIL seq_addr[%0d] got %h want %h", i, a, i * 4); end
      if (i > 0) begin
        checks++; if (t - t_prev != period) begin
          errors++; $display("FAIL seq_period[%0d] got %0d want %0d", i, t - t_prev, period); end
      end
      t_prev = t;
      w = W_ADDI | (32'(i) << 20);
      ack_with(w, delay);
      checks++; if (b0.inst_valid !== 1'b1 || b0.inst_pc !== a || b0.inst_out !== w) begin
        errors++; $display("FAIL seq_inst[%0d] v=%b pc=%h out=%h want 1/%h/%h", i, b0.inst_valid, b0.inst_pc, b0.inst_out, a, w); end
    end
  endtask

  task automatic test_branch(input logic taken, input logic [31:0] tgt, input logic [31:0] exp_next);
    logic [31:0] a;
    int t;
    do_reset(1);
    b0.inst_ready = 1;
    for (int i = 0; i < 4; i++) begin
      wait_req(a, t);
      ack_with(W_ADDI, 0);
    end
    wait_req(a, t);
    checks++; if (a !== 32'h10) begin errors++; $display("FAIL br_addr got %h want 10", a); end
    ack_with(W_BEQ, 0);
    for (int n = 1; n <= 3; n++) begin
      cyc();
      checks++; if (b0.imem_req !== 1'b0) begin errors++; $display("FAIL br_wait_req[%0d] got %b want 0", n, b0.imem_req); end
      if (n == 3) begin
        b0.resolve_valid = 1; b0.resolve_taken = taken; b0.resolve_target = tgt;
      end
    end
    cyc();
    b0.resolve_valid = 0;
    checks++; if (b0.imem_req !== 1'b1 || b0.imem_addr !== exp_next) begin
      errors++; $display("FAIL br_next req=%b addr=%h want 1/%h", b0.imem_req, b0.imem_addr, exp_next); end
    checks++; if (b0.bubble_cnt !== 32'd3) begin errors++; $display("FAIL br_bubble got %0d want 3", b0.bubble_cnt); end
    checks++; if (b0.misalign !== 1'b0) begin errors++; $display("FAIL br_misalign got %b want 0", b0.misalign); end
  endtask

  task automatic test_jalr_misalign();
    logic [31:0] a;
    int t;
    do_reset(1);
    b0.inst_ready = 1;
    wait_req(a, t);
    ack_with(W_JALR, 0);
    cyc(); cyc();
    checks++; if (b0.misalign !== 1'b0) begin errors++; $display("FAIL jalr_pre_mis got %b want 0", b0.misalign); end
    b0.resolve_valid = 1; b0.resolve_taken = 1; b0.resolve_target = 32'h43;
    cyc();
    b0.resolve_valid = 0;
    checks++; if (b0.misalign !== 1'b1) begin errors++; $display("FAIL jalr_mis got %b want 1", b0.misalign); end
    checks++; if (b0.imem_req !== 1'b1 || b0.imem_addr !== 32'h40) begin
      errors++; $display("FAIL jalr_addr req=%b addr=%h want 1/40", b0.imem_req, b0.imem_addr); end
    cyc();
    checks++; if (b0.misalign !== 1'b0) begin errors++; $display("FAIL jalr_mis_pulse got %b want 0", b0.misalign); end
  endtask

  task automatic test_hold_stall();
    logic [31:0] a;
    int t;
    do_reset(1);
    wait_req(a, t);
    ack_with(W_ADDI, 0);
    for (int i = 0; i < 5; i++) begin
      b0.imem_ack = 1; b0.resolve_valid = 1; b0.resolve_taken = 1; b0.resolve_target = 32'h83;
      cyc();
      checks++; if (b0.inst_valid !== 1'b1 || b0.inst_out !== W_ADDI || b0.inst_pc !== 32'h0 || b0.imem_req !== 1'b0 || b0.misalign !== 1'b0) begin
        errors++; $display("FAIL stall[%0d] v=%b out=%h pc=%h req=%b mis=%b want 1/%h/0/0/0", i, b0.inst_valid, b0.inst_out, b0.inst_pc, b0.imem_req, b0.misalign, W_ADDI); end
    end
    b0.imem_ack = 0; b0.resolve_valid = 0;
    b0.inst_ready = 1; b0.fetch_en = 0;
    cyc();
    b0.inst_ready = 0;
    checks++; if (b0.inst_valid !== 1'b0 || b0.imem_req !== 1'b0 || b0.imem_addr !== 32'h4) begin
      errors++; $display("FAIL stall_park v=%b req=%b addr=%h want 0/0/4", b0.inst_valid, b0.imem_req, b0.imem_addr); end
    repeat (3) cyc();
    checks++; if (b0.imem_req !== 1'b0) begin errors++; $display("FAIL stall_idle got %b want 0", b0.imem_req); end
  endtask

  task automatic test_drain();
    logic [31:0] a;
    int t;
    do_reset(1);
    wait_req(a, t);
    b0.fetch_en = 0;
    ack_with(W_ADDI ^ 32'h0F00_0000, 2);
    checks++; if (b0.inst_valid !== 1'b1 || b0.inst_out !== (W_ADDI ^ 32'h0F00_0000) || b0.inst_pc !== 32'h0) begin
      errors++; $display("FAIL drain_inst v=%b out=%h pc=%h want 1/%h/0", b0.inst_valid, b0.inst_out, b0.inst_pc, W_ADDI ^ 32'h0F00_0000); end
    b0.inst_ready = 1;
    cyc();
    b0.inst_ready = 0;
    cyc();
    checks++; if (b0.inst_valid !== 1'b0 || b0.imem_req !== 1'b0 || b0.imem_addr !== 32'h4) begin
      errors++; $display("FAIL drain_park v=%b req=%b addr=%h want 0/0/4", b0.inst_valid, b0.imem_req, b0.imem_addr); end
  endtask

  task automatic test_reset_in_wait();
    logic [31:0] a;
    int t;
    do_reset(1);
    b0.inst_ready = 1;
    wait_req(a, t);
    ack_with(W_JAL, 0);
    repeat (3) cyc();
    checks++; if (b0.bubble_cnt !== 32'd2) begin errors++; $display("FAIL wait_bubble got %0d want 2", b0.bubble_cnt); end
    RESET = 1;
    cyc();
    checks++; if (b0.imem_req !== 1'b0 || b0.inst_valid !== 1'b0 || b0.inst_out !== 32'h0 || b0.inst_pc !== 32'h0 ||
                   b0.misalign !== 1'b0 || b0.bubble_cnt !== 32'h0 || b0.imem_addr !== 32'h0) begin
      errors++; $display("FAIL wait_reset req=%b v=%b out=%h pc=%h mis=%b bub=%0d addr=%h want all 0",
                         b0.imem_req, b0.inst_valid, b0.inst_out, b0.inst_pc, b0.misalign, b0.bubble_cnt, b0.imem_addr); end
    RESET = 0;
  endtask

  task automatic test_wrap();
    int n = 0;
    do_reset(0);
    b1.fetch_en = 1; b1.inst_ready = 1;
    while (b1.imem_req !== 1'b1 && n < 40) begin cyc(); n++; end
    checks++; if (b1.imem_req !== 1'b1 || b1.imem_addr !== 32'hFFFF_FFFC) begin
      errors++; $display("FAIL wrap_first req=%b addr=%h want 1/fffffffc", b1.imem_req, b1.imem_addr); end
    b1.imem_ack = 1; b1.imem_rdata = W_ADDI;
    cyc();
    b1.imem_ack = 0;
    checks++; if (b1.inst_pc !== 32'hFFFF_FFFC || b1.inst_pc4 !== 32'h0) begin
      errors++; $display("FAIL wrap_pc4 pc=%h pc4=%h want fffffffc/0", b1.inst_pc, b1.inst_pc4); end
    cyc();
    checks++; if (b1.imem_req !== 1'b1 || b1.imem_addr !== 32'h0) begin
      errors++; $display("FAIL wrap_next req=%b addr=%h want 1/0", b1.imem_req, b1.imem_addr); end
    b1.fetch_en = 0; b1.inst_ready = 0;
  endtask

  // Model tracks only the architectural PC, the last delivered word and the stall count.
  task automatic test_random(input int ncyc);
    logic [31:0] exp_pc, exp_inst, exp_ipc, bub, tgt, w;
    logic        mis_exp, pend, tk;
    int          pn, pk;
    do_reset(1);
    exp_pc = 0; exp_inst = 0; exp_ipc = 0; bub = 0; mis_exp = 0; pend = 0; pn = 0; pk = 0;
    for (int c = 0; c < ncyc; c++) begin
      checks++; if (b0.bubble_cnt !== bub) begin errors++; $display("FAIL rnd_bubble c=%0d got %0d want %0d", c, b0.bubble_cnt, bub); end
      checks++; if (b0.misalign !== mis_exp) begin errors++; $display("FAIL rnd_misalign c=%0d got %b want %b", c, b0.misalign, mis_exp); end
      mis_exp = 0;
      b0.imem_ack = 0; b0.resolve_valid = 0; b0.inst_ready = 0;
      b0.resolve_taken = 1'($urandom); b0.resolve_target = $urandom;
      b0.imem_rdata = $urandom;
      if (pend) begin
        checks++; if (b0.imem_req !== 1'b0 || b0.inst_valid !== 1'b0) begin
          errors++; $display("FAIL rnd_wait c=%0d req=%b v=%b want 0/0", c, b0.imem_req, b0.inst_valid); end
        pn++; bub++;
        if (pn == pk) begin
          tk = 1'($urandom); tgt = $urandom;
          b0.resolve_valid = 1; b0.resolve_taken = tk; b0.resolve_target = tgt;
          if (tk) begin exp_pc = tgt & 32'hFFFF_FFFC; mis_exp = (tgt[1:0] != 2'b00); end
          else exp_pc = exp_pc + 32'd4;
          pend = 0;
        end
      end else if (b0.inst_valid === 1'b1) begin
        checks++; if (b0.inst_out !== exp_inst || b0.inst_pc !== exp_ipc || b0.inst_pc4 !== exp_ipc + 32'd4 || b0.imem_req !== 1'b0) begin
          errors++; $display("FAIL rnd_inst c=%0d out=%h pc=%h pc4=%h req=%b want %h/%h/%h/0", c, b0.inst_out, b0.inst_pc, b0.inst_pc4, b0.imem_req, exp_inst, exp_ipc, exp_ipc + 32'd4); end
        b0.imem_ack = ($urandom_range(0, 3) == 0);
        b0.resolve_valid = ($urandom_range(0, 3) == 0);
        if ($urandom_range(0, 2) != 0) begin
          b0.inst_ready = 1;
          if (xfer_op(exp_inst)) begin pend = 1; pn = 0; pk = $urandom_range(2, 5); end
          else exp_pc = exp_pc + 32'd4;
        end
      end else if (b0.imem_req === 1'b1) begin
        checks++; if (b0.imem_addr !== exp_pc) begin errors++; $display("FAIL rnd_addr c=%0d got %h want %h", c, b0.imem_addr, exp_pc); end
        b0.resolve_valid = ($urandom_range(0, 3) == 0);
        if ($urandom_range(0, 1) == 0) begin
          w = gen_word();
          b0.imem_ack = 1; b0.imem_rdata = w;
          exp_inst = w; exp_ipc = exp_pc;
        end
      end else begin
        b0.imem_ack = ($urandom_range(0, 3) == 0);
        b0.resolve_valid = ($urandom_range(0, 3) == 0);
      end
      b0.fetch_en = ($urandom_range(0, 7) != 0);
      cyc();
    end
    init_inputs(0);
  endtask

  initial begin
    init_inputs(0);
    cyc();
    test_reset();
    test_sequential(1, 3);
    test_sequential(0, 2);
    test_branch(1'b1, 32'h40, 32'h40);
    test_branch(1'b0, 32'h40, 32'h14);
    test_jalr_misalign();
    test_hold_stall();
    test_drain();
    test_reset_in_wait();
    test_wrap();
    test_random(4000);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
